// File: rtl/x_mem_pkg.sv
// Shared types and defaults for the 23K640 memory context path (arbiter, crossbar, controllers).
package x_mem_pkg;

    localparam int X_MEM_AW = 16;
    localparam int X_MEM_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } x_memarb_state_t;

endpackage

// File: rtl/x_rr_pick.sv
// Combinational pick of the first set request at or after ptr, wrapping at N (not at 2^clog2(N)).
// Zero latency; no flow control of its own.
module x_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) sum = sum - N;
        return IW'(sum);
    endfunction

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!any && req[wrap_add(ptr, off)]) begin
                gnt_idx = wrap_add(ptr, off);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/x_memarb.sv
// Round-robin arbiter sharing one memory context port among N requesters (X_MEMARB_FIXED_PRIO_EN: lowest index wins).
// Latency: 1 arbitration cycle before o_mem_valid; grant held until write accept or read data return.
// Backpressure: requesters wait on o_req_accept; i_mem_accept stalls REQ; i_mem_ready closes a read.
module x_memarb
    import x_mem_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = X_MEM_AW,
    parameter int DW = X_MEM_DW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    i_req_valid,
    output logic [N-1:0]    o_req_accept,
    input  logic [N-1:0]    i_req_rd_n_wr,
    input  logic [N*AW-1:0] i_req_addr,
    input  logic [N*DW-1:0] i_req_wdata,
    output logic [N-1:0]    o_req_ready,
    output logic [DW-1:0]   o_req_rdata,
    output logic            o_mem_valid,
    input  logic            i_mem_accept,
    output logic            o_mem_rd_n_wr,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    input  logic            i_mem_ready,
    input  logic [DW-1:0]   i_mem_rdata
);

    localparam int             IW   = $clog2(N);
    localparam logic [IW-1:0]  LAST = IW'(N - 1);

    x_memarb_state_t state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   grant_next;
    logic            xfer_done;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   pick_ptr;
    logic            pick_any;

    logic [AW-1:0] addr_arr  [N];
    logic [DW-1:0] wdata_arr [N];

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign addr_arr[k]  = i_req_addr[k*AW +: AW];
        assign wdata_arr[k] = i_req_wdata[k*DW +: DW];
    end

    assign grant_next = (grant_q == LAST) ? '0 : grant_q + 1'b1;

`ifdef X_MEMARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IW-1:0] rr_ptr_q;

    assign pick_ptr = rr_ptr_q;

    // Pointer only moves once the granted transaction has fully completed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q <= '0;
        end else if (xfer_done) begin
            rr_ptr_q <= grant_next;
        end
    end
`endif

    x_rr_pick #(
        .N (N)
    ) u_pick (
        .req     (i_req_valid),
        .ptr     (pick_ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        xfer_done     = 1'b0;
        o_mem_valid   = 1'b0;
        o_mem_rd_n_wr = 1'b0;
        o_mem_addr    = '0;
        o_mem_wdata   = '0;
        o_req_accept  = '0;
        o_req_ready   = '0;
        o_req_rdata   = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                o_mem_valid   = 1'b1;
                o_mem_rd_n_wr = i_req_rd_n_wr[grant_q];
                o_mem_addr    = addr_arr[grant_q];
                o_mem_wdata   = wdata_arr[grant_q];
                if (i_mem_accept) begin
                    o_req_accept[grant_q] = 1'b1;
                    if (!i_req_rd_n_wr[grant_q]) begin
                        state_d   = IDLE;
                        xfer_done = 1'b1;
                    end else if (i_mem_ready) begin
                        // Memory answered in the accept cycle: close the read right here.
                        o_req_ready[grant_q] = 1'b1;
                        o_req_rdata          = i_mem_rdata;
                        state_d              = IDLE;
                        xfer_done            = 1'b1;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (i_mem_ready) begin
                    o_req_ready[grant_q] = 1'b1;
                    o_req_rdata          = i_mem_rdata;
                    state_d              = IDLE;
                    xfer_done            = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshakes seen during reset would be lost with the state, so keep every output quiet.
        if (i_rst) begin
            o_mem_valid   = 1'b0;
            o_mem_rd_n_wr = 1'b0;
            o_mem_addr    = '0;
            o_mem_wdata   = '0;
            o_req_accept  = '0;
            o_req_ready   = '0;
            o_req_rdata   = '0;
        end
    end

endmodule
